gpio_input_stage16: RTL and testbench

//  Input-side stage fed by the GPIO pad signals gpio_pin_in16 / n_gpio_pin_oe16 carried on the GPIO interface.

---
 rtl/gpio_input_stage16.sv | 72 +++++++
 tb/tb_gpio_input_stage16.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_stage16.sv
// rtl/gpio_input_stage16.sv - GPIO input synchroniser, debouncer, edge detector and sticky W1C interrupt status
module gpio_input_stage16 #(
    parameter int DATA_W = 16,
    parameter int DEB_W  = 4
) (
    input  logic              pclk16,
    input  logic              n_p_reset16,
    input  logic [DATA_W-1:0] gpio_pin_in16,
    input  logic [DATA_W-1:0] n_gpio_pin_oe16,
    input  logic [DEB_W-1:0]  cfg_deb_limit16,
    input  logic [DATA_W-1:0] cfg_rise_en16,
    input  logic [DATA_W-1:0] cfg_fall_en16,
    input  logic [DATA_W-1:0] irq_clr16,
    output logic [DATA_W-1:0] pin_value16,
    output logic [DATA_W-1:0] irq_status16,
    output logic              gpio_irq16
);

    logic [DATA_W-1:0]            s1_q, s1_d;
    logic [DATA_W-1:0]            s2_q, s2_d;
    logic [DATA_W-1:0]            pin_value_q, pin_value_d;
    logic [DATA_W-1:0]            irq_status_q, irq_status_d;
    logic [DATA_W-1:0][DEB_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]            upd;
    logic [DATA_W-1:0]            rise_evt;
    logic [DATA_W-1:0]            fall_evt;

    always_comb begin
        s1_d        = gpio_pin_in16;
        s2_d        = s1_q;
        pin_value_d = pin_value_q;
        cnt_d       = cnt_q;
        upd         = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (s2_q[i] == pin_value_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= cfg_deb_limit16) begin
                // '>=' lets a limit lowered mid-count take effect on the next edge
                pin_value_d[i] = s2_q[i];
                cnt_d[i]       = '0;
                upd[i]         = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + DEB_W'(1);
            end
        end
        rise_evt     = upd &  s2_q & n_gpio_pin_oe16 & cfg_rise_en16;
        fall_evt     = upd & ~s2_q & n_gpio_pin_oe16 & cfg_fall_en16;
        // set has priority over a coincident clear
        irq_status_d = (irq_status_q & ~irq_clr16) | rise_evt | fall_evt;
    end

    always_ff @(posedge pclk16 or negedge n_p_reset16) begin
        if (!n_p_reset16) begin
            s1_q         <= '0;
            s2_q         <= '0;
            pin_value_q  <= '0;
            irq_status_q <= '0;
            cnt_q        <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            pin_value_q  <= pin_value_d;
            irq_status_q <= irq_status_d;
            cnt_q        <= cnt_d;
        end
    end

    assign pin_value16  = pin_value_q;
    assign irq_status16 = irq_status_q;
    assign gpio_irq16   = |irq_status_q;

endmodule

// File: tb/tb_gpio_input_stage16.sv
// tb/tb_gpio_input_stage16.sv - table-driven and scoreboard bench for gpio_input_stage16
module tb_gpio_input_stage16;

    logic        pclk16 = 1'b0;
    logic        n_p_reset16;
    logic [15:0] gpio_pin_in16;
    logic [15:0] n_gpio_pin_oe16;
    logic [3:0]  cfg_deb_limit16;
    logic [15:0] cfg_rise_en16;
    logic [15:0] cfg_fall_en16;
    logic [15:0] irq_clr16;
    logic [15:0] pin_value16;
    logic [15:0] irq_status16;
    logic        gpio_irq16;

    gpio_input_stage16 #(.DATA_W(16), .DEB_W(4)) dut (
        .pclk16          (pclk16),
        .n_p_reset16     (n_p_reset16),
        .gpio_pin_in16   (gpio_pin_in16),
        .n_gpio_pin_oe16 (n_gpio_pin_oe16),
        .cfg_deb_limit16 (cfg_deb_limit16),
        .cfg_rise_en16   (cfg_rise_en16),
        .cfg_fall_en16   (cfg_fall_en16),
        .irq_clr16       (irq_clr16),
        .pin_value16     (pin_value16),
        .irq_status16    (irq_status16),
        .gpio_irq16      (gpio_irq16)
    );

    always #5 pclk16 = ~pclk16;

    typedef struct {
        string       name;
        logic [15:0] pin;
        logic [15:0] st;
        logic        irq;
    } exp_t;

    typedef struct {
        logic [15:0] pin;
        logic [15:0] oe;
        logic [15:0] rise;
        logic [15:0] fall;
        logic [15:0] clr;
        logic [3:0]  lim;
        int          cyc;
        logic [15:0] epin;
        logic [15:0] est;
        logic        eirq;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[12];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_out(input string name, input logic [15:0] p, input logic [15:0] s, input logic i);
        exp_t e;
        e.name = name;
        e.pin  = p;
        e.st   = s;
        e.irq  = i;
        sb.push_back(e);
    endtask

    task automatic compare_now();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: output sampled with no expectation queued");
        end else begin
            e = sb.pop_front();
            if (pin_value16 !== e.pin || irq_status16 !== e.st || gpio_irq16 !== e.irq) begin
                errors++;
                $display("FAIL %s: got pin=%h st=%h irq=%b, want pin=%h st=%h irq=%b",
                         e.name, pin_value16, irq_status16, gpio_irq16, e.pin, e.st, e.irq);
            end
        end
    endtask

    task automatic sample();
        @(negedge pclk16);
        compare_now();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk16);
        #1;
    endtask

    task automatic clr_pulse(input logic [15:0] m);
        irq_clr16 = m;
        @(posedge pclk16);
        #1;
        irq_clr16 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          pin      oe       rise     fall     clr      L  cyc epin     est      irq
        vecs[0]  = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 3, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 2, 16'h0000, 16'h0000, 1'b0};
        vecs[2]  = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 1, 16'h0001, 16'h0001, 1'b1};
        vecs[3]  = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 4'd0, 1, 16'h0001, 16'h0000, 1'b0};
        vecs[4]  = '{16'h0005, 16'hFFFB, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 3, 16'h0005, 16'h0000, 1'b0};
        vecs[5]  = '{16'h0001, 16'hFFFB, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 3, 16'h0001, 16'h0000, 1'b0};
        vecs[6]  = '{16'h0081, 16'hFFFF, 16'hFF7F, 16'h0080, 16'h0000, 4'd0, 3, 16'h0081, 16'h0000, 1'b0};
        vecs[7]  = '{16'h0001, 16'hFFFF, 16'hFF7F, 16'h0080, 16'h0000, 4'd0, 3, 16'h0001, 16'h0080, 1'b1};
        vecs[8]  = '{16'h0001, 16'hFFFF, 16'hFF7F, 16'h0000, 16'h0000, 4'd0, 1, 16'h0001, 16'h0080, 1'b1};
        vecs[9]  = '{16'h0001, 16'hFFFF, 16'hFF7F, 16'h0000, 16'h0080, 4'd0, 1, 16'h0001, 16'h0000, 1'b0};
        vecs[10] = '{16'h0081, 16'hFFFF, 16'hFF7F, 16'h0080, 16'h0000, 4'd0, 3, 16'h0081, 16'h0000, 1'b0};
        vecs[11] = '{16'h0081, 16'hFFFF, 16'hFF7F, 16'h0080, 16'h0100, 4'd0, 1, 16'h0081, 16'h0000, 1'b0};

        n_p_reset16     = 1'b0;
        gpio_pin_in16   = '0;
        n_gpio_pin_oe16 = '1;
        cfg_deb_limit16 = '0;
        cfg_rise_en16   = '1;
        cfg_fall_en16   = '0;
        irq_clr16       = '0;
        #3;
        expect_out("reset_state", 16'h0000, 16'h0000, 1'b0);
        compare_now();
        tick(2);
        n_p_reset16 = 1'b1;

        for (int i = 0; i < 12; i++) begin
            gpio_pin_in16   = vecs[i].pin;
            n_gpio_pin_oe16 = vecs[i].oe;
            cfg_rise_en16   = vecs[i].rise;
            cfg_fall_en16   = vecs[i].fall;
            cfg_deb_limit16 = vecs[i].lim;
            expect_out($sformatf("vec%0d", i), vecs[i].epin, vecs[i].est, vecs[i].eirq);
            clr_pulse(vecs[i].clr);
            if (vecs[i].cyc > 1) tick(vecs[i].cyc - 1);
            sample();
        end

        // glitches shorter than L+1 cycles are filtered, L+1 passes at edge 3+L
        cfg_deb_limit16 = 4'd5;
        gpio_pin_in16 = 16'h0089;
        tick(1);
        gpio_pin_in16 = 16'h0081;
        tick(12);
        expect_out("glitch_1cyc", 16'h0081, 16'h0000, 1'b0);
        sample();
        gpio_pin_in16 = 16'h0089;
        tick(5);
        gpio_pin_in16 = 16'h0081;
        tick(12);
        expect_out("glitch_5cyc", 16'h0081, 16'h0000, 1'b0);
        sample();
        gpio_pin_in16 = 16'h0089;
        tick(6);
        gpio_pin_in16 = 16'h0081;
        tick(1);
        expect_out("pulse6_edge7", 16'h0081, 16'h0000, 1'b0);
        sample();
        expect_out("pulse6_edge8", 16'h0089, 16'h0008, 1'b1);
        sample();
        tick(10);
        expect_out("pulse6_clr", 16'h0081, 16'h0000, 1'b0);
        clr_pulse(16'h0008);
        sample();

        // set and clear on the same edge: set wins
        cfg_deb_limit16 = 4'd0;
        gpio_pin_in16 = 16'h0080;
        tick(4);
        expect_out("pin0_low", 16'h0080, 16'h0000, 1'b0);
        sample();
        gpio_pin_in16 = 16'h0081;
        tick(2);
        expect_out("set_beats_clr", 16'h0081, 16'h0001, 1'b1);
        clr_pulse(16'h0001);
        sample();
        tick(1);
        expect_out("status_held", 16'h0081, 16'h0001, 1'b1);
        sample();
        expect_out("clr_alone", 16'h0081, 16'h0000, 1'b0);
        clr_pulse(16'h0001);
        sample();

        // lowering L mid-count resolves on the next edge
        cfg_deb_limit16 = 4'd10;
        gpio_pin_in16 = 16'h0091;
        tick(8);
        cfg_deb_limit16 = 4'd2;
        expect_out("lowerL_before", 16'h0081, 16'h0000, 1'b0);
        sample();
        expect_out("lowerL_after", 16'h0091, 16'h0010, 1'b1);
        sample();
        expect_out("lowerL_clr", 16'h0091, 16'h0000, 1'b0);
        clr_pulse(16'h0010);
        sample();

        // async reset in the middle of a count
        cfg_deb_limit16 = 4'd15;
        gpio_pin_in16 = 16'h00B1;
        tick(11);
        n_p_reset16 = 1'b0;
        #1;
        expect_out("async_reset", 16'h0000, 16'h0000, 1'b0);
        compare_now();
        gpio_pin_in16 = 16'h0000;
        tick(2);
        n_p_reset16 = 1'b1;
        tick(25);
        expect_out("no_event_after_reset", 16'h0000, 16'h0000, 1'b0);
        sample();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
